inv_sqrt_scheduler: RTL and testbench
=====================================

INV_SQRT_SCHEDULER -- requirements
Module: inv_sqrt_scheduler

Interface
REQ-001 Parameter WIDTH, 32, data width (Q8.24).
REQ-002 Parameter NUM_REQ, 4, number of requesters sharing one inverse-square-root unit.
REQ-003 Parameter UNIT_LAT, 2, fixed cycles from unit valid_in to unit valid_out.
REQ-004 Parameter FIFO_DEPTH, 4, result buffer entries (power of two, >= 2).
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-009 req_data  in  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-010 req_ready  out  NUM_REQ  one-hot (or zero) grant; handshake = req_valid[i] & req_ready[i].
REQ-011 sq_valid_in  out  1  issue strobe to shared unit.
REQ-012 sq_x  out  WIDTH  operand to shared unit.
REQ-013 sq_valid_out  in  1  result strobe from shared unit; no backpressure possible.
REQ-014 sq_result  in  WIDTH  unit result.
REQ-015 resp_valid  out  1  head of result buffer valid.
REQ-016 resp_id  out  $clog2(NUM_REQ)  requester index owning resp_data.
REQ-017 resp_data  out  WIDTH  result value.
REQ-018 resp_ready  in  1  consumer accepts head when high with resp_valid.
REQ-019 busy  out  1  high when any operation is in flight or buffered.
REQ-020 err_orphan  out  1  sticky: unit result arrived with no outstanding tag.

Function
REQ-021 Round-robin arbitration: search starts at rr_ptr, picks first i with req_valid[i]; req_ready combinational from arbitration and credit.
REQ-022 Credit = FIFO_DEPTH - buffer occupancy - in-flight count; req_ready all zero when credit == 0.
REQ-023 On handshake of requester g: rr_ptr <= (g+1) mod NUM_REQ; rr_ptr unchanged when no handshake.
REQ-024 Handshake in cycle N registers sq_valid_in=1, sq_x=req_data[g] in cycle N+1; sq_valid_in=0 otherwise; sq_x holds last value.
REQ-025 At most one issue per cycle; back-to-back issues every cycle while credit > 0.
REQ-026 Tag FIFO (depth >= UNIT_LAT+1) pushes g on issue, pops on sq_valid_out; unit is in-order.
REQ-027 In-flight counter +1 on issue, -1 on sq_valid_out; both in same cycle leaves it unchanged.
REQ-028 On sq_valid_out with tag available: push {tag, sq_result} into result buffer in same edge; credit guarantees no overflow.
REQ-029 On sq_valid_out with empty tag FIFO: result dropped, err_orphan set until rst.
REQ-030 Result buffer is first-word registered: earliest resp_valid is cycle after sq_valid_out; end-to-end latency handshake-to-resp_valid = UNIT_LAT+2 cycles.
REQ-031 Pop on resp_valid & resp_ready; simultaneous push and pop keeps occupancy; full buffer with pop frees credit next cycle, not same cycle.
REQ-032 resp_id/resp_data stable while resp_valid & !resp_ready.
REQ-033 Pointers wrap mod FIFO_DEPTH; full/empty from occupancy counter, not pointer compare.
REQ-034 busy = (in-flight != 0) | (occupancy != 0) | sq_valid_in.
REQ-035 Operand values are opaque; zero and negative inputs forwarded unmodified.

Reset
REQ-036 While rst high at an edge: req_ready=0, sq_valid_in=0, sq_x=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, err_orphan=0, rr_ptr=0, counters and FIFOs empty.
REQ-037 Reset mid-operation discards in-flight and buffered results; the shared unit is reset by the same rst, so no stale sq_valid_out follows.
REQ-038 First grant possible in the cycle after rst deasserts.

Verification
REQ-039 Single request: req 2 valid, data 0x01000000, unit model returns 0x01000000 -> sq_valid_in cycle 1, resp_valid cycle 4 with resp_id=2, resp_data=0x01000000.
REQ-040 All four requesting continuously, resp_ready=1 -> grants 0,1,2,3,0,... one per cycle, responses in same order.
REQ-041 resp_ready=0, all requesting -> exactly 4 issues, then req_ready=0; raising resp_ready for one cycle -> exactly one new issue the following cycle.
REQ-042 Only req 3 valid after grant to 1 -> req 3 granted immediately, rr_ptr becomes 0.
REQ-043 Force sq_valid_out=1 with nothing issued -> no resp_valid, err_orphan=1 until rst.
REQ-044 Assert rst with 2 in flight and 2 buffered -> next cycle all outputs at reset values, busy=0, no later resp_valid.

Source files
------------

// File: rtl/inv_sqrt_scheduler_if.sv
// Bundles the requester, shared-unit and response signals of the scheduler.
// slave is the scheduler's own view; master is the surrounding environment.
interface inv_sqrt_scheduler_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     sq_valid_in;
    logic [WIDTH-1:0]         sq_x;
    logic                     sq_valid_out;
    logic [WIDTH-1:0]         sq_result;
    logic                     resp_valid;
    logic [IdW-1:0]           resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     resp_ready;
    logic                     busy;
    logic                     err_orphan;

    modport master (
        output req_valid, req_data, sq_valid_out, sq_result, resp_ready,
        input  req_ready, sq_valid_in, sq_x, resp_valid, resp_id, resp_data, busy, err_orphan
    );

    modport slave (
        input  req_valid, req_data, sq_valid_out, sq_result, resp_ready,
        output req_ready, sq_valid_in, sq_x, resp_valid, resp_id, resp_data, busy, err_orphan
    );
endinterface

// File: rtl/inv_sqrt_scheduler.sv
// Round-robin scheduler sharing one pipelined inverse-square-root unit among
// NUM_REQ requesters. Issues are credit-limited so every result the unit
// returns always has room in the result buffer (the unit cannot be stalled).
module inv_sqrt_scheduler #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned UNIT_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    inv_sqrt_scheduler_if.slave bus
);
    localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
    // Tag FIFO must hold at least everything the unit pipeline can carry.
    localparam int unsigned TagMin   = (FIFO_DEPTH > UNIT_LAT + 1) ? FIFO_DEPTH : UNIT_LAT + 1;
    localparam int unsigned TagPtrW  = $clog2(TagMin);
    localparam int unsigned TagDepth = 1 << TagPtrW;
    localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FIFO_DEPTH);

    logic [IdW-1:0]     rr_q, rr_d;
    logic               sq_valid_q, sq_valid_d;
    logic [WIDTH-1:0]   sq_x_q, sq_x_d;
    logic [CntW-1:0]    inflight_q, inflight_d;
    logic [CntW-1:0]    occ_q, occ_d;
    logic [TagPtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PtrW-1:0]    res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic               err_q, err_d;

    logic [IdW-1:0]     tag_mem      [TagDepth];
    logic [IdW-1:0]     res_id_mem   [FIFO_DEPTH];
    logic [WIDTH-1:0]   res_data_mem [FIFO_DEPTH];

    logic               no_credit;
    logic               found;
    logic [IdW-1:0]     arb_idx;
    logic [IdW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               issue, tag_avail, push, pop, resp_valid;

    // In-flight work plus buffered results may never exceed the buffer size.
    assign no_credit  = ({1'b0, occ_q} + {1'b0, inflight_q}) >= DepthCnt;
    assign tag_avail  = (inflight_q != '0);
    assign push       = bus.sq_valid_out & tag_avail;
    assign resp_valid = (occ_q != '0);
    assign pop        = resp_valid & bus.resp_ready;
    assign issue      = found;

    // Round-robin search starting at rr_q; grant only while credit remains.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        if (!rst && !no_credit) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                arb_idx = IdW'((32'(rr_q) + k) % NUM_REQ);
                if (!found && bus.req_valid[arb_idx]) begin
                    found     = 1'b1;
                    grant_idx = arb_idx;
                end
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Next-state for pointers, counters, issue register and sticky error.
    always_comb begin
        rr_d       = rr_q;
        sq_valid_d = 1'b0;
        sq_x_d     = sq_x_q;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        res_wr_d   = res_wr_q;
        res_rd_d   = res_rd_q;
        err_d      = err_q | (bus.sq_valid_out & ~tag_avail);

        if (issue) begin
            rr_d       = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
            sq_valid_d = 1'b1;
            sq_x_d     = bus.req_data[grant_idx*WIDTH +: WIDTH];
            tag_wr_d   = tag_wr_q + TagPtrW'(1);
        end
        if (push) begin
            tag_rd_d = tag_rd_q + TagPtrW'(1);
            res_wr_d = res_wr_q + PtrW'(1);
        end
        if (pop) begin
            res_rd_d = res_rd_q + PtrW'(1);
        end

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({push, pop})
            2'b10:   occ_d = occ_q + CntW'(1);
            2'b01:   occ_d = occ_q - CntW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            sq_valid_q <= 1'b0;
            sq_x_q     <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            res_wr_q   <= '0;
            res_rd_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            sq_valid_q <= sq_valid_d;
            sq_x_q     <= sq_x_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            res_wr_q   <= res_wr_d;
            res_rd_q   <= res_rd_d;
            err_q      <= err_d;
        end
    end

    // Storage arrays; validity is tracked by the counters, so no reset needed.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr_q] <= grant_idx;
        end
        if (push) begin
            res_id_mem[res_wr_q]   <= tag_mem[tag_rd_q];
            res_data_mem[res_wr_q] <= bus.sq_result;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.sq_valid_in = sq_valid_q;
    assign bus.sq_x        = sq_x_q;
    assign bus.resp_valid  = resp_valid;
    // Head is masked when empty so idle/reset outputs read as zero.
    assign bus.resp_id     = resp_valid ? res_id_mem[res_rd_q] : '0;
    assign bus.resp_data   = resp_valid ? res_data_mem[res_rd_q] : '0;
    assign bus.busy        = (inflight_q != '0) | (occ_q != '0) | sq_valid_q;
    assign bus.err_orphan  = err_q;
endmodule

// File: tb/tb_inv_sqrt_scheduler.sv
// Self-checking bench: transaction-level queue model of the scheduler plus a
// fixed-latency model of the shared unit, with directed literal checks.
module tb_inv_sqrt_scheduler;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned UNIT_LAT   = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_sqrt_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    inv_sqrt_scheduler #(
        .WIDTH      (WIDTH),
        .NUM_REQ    (NUM_REQ),
        .UNIT_LAT   (UNIT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int failures;

    // Stimulus for the next cycle.
    logic                     s_rst;
    logic [NUM_REQ-1:0]       s_valid;
    logic [NUM_REQ*WIDTH-1:0] s_data;
    logic                     s_rready;
    logic                     s_force;

    // Shared-unit pipeline model.
    logic             uv [UNIT_LAT];
    logic [WIDTH-1:0] ud [UNIT_LAT];

    // Reference model state.
    bit               model_ok;
    int               m_rr;
    bit               m_sqv;
    logic [WIDTH-1:0] m_sqx;
    bit               m_err;
    int               pend_id [$];
    logic [WIDTH-1:0] pend_x  [$];
    int               buf_id  [$];
    logic [WIDTH-1:0] buf_d   [$];

    // Values observed in the most recent cycle.
    logic [NUM_REQ-1:0] obs_ready;
    logic               obs_sqv;
    logic [WIDTH-1:0]   obs_sqx;
    logic               obs_rv;
    logic [1:0]         obs_rid;
    logic [WIDTH-1:0]   obs_rdata;
    logic               obs_busy;
    logic               obs_err;
    logic               obs_hs;
    int                 obs_gidx;

    function automatic logic [WIDTH-1:0] unit_f(input logic [WIDTH-1:0] x);
        if (x == 32'h0100_0000) return x;
        return (x ^ 32'h5A5A_A5A5) + 32'd7;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive, observe, compare with model, advance model.
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_ready;
        int g;
        int idx;
        logic uvo;
        logic [WIDTH-1:0] tmp_x;
        int tmp_id;

        rst              = s_rst;
        bus.req_valid    = s_valid;
        bus.req_data     = s_data;
        bus.resp_ready   = s_rready;
        uvo              = uv[UNIT_LAT-1];
        bus.sq_valid_out = uvo | s_force;
        bus.sq_result    = uvo ? unit_f(ud[UNIT_LAT-1]) : 32'hDEAD_BEEF;
        #1;
        obs_ready = bus.req_ready;
        obs_sqv   = bus.sq_valid_in;
        obs_sqx   = bus.sq_x;
        obs_rv    = bus.resp_valid;
        obs_rid   = bus.resp_id;
        obs_rdata = bus.resp_data;
        obs_busy  = bus.busy;
        obs_err   = bus.err_orphan;
        obs_hs    = |(s_valid & obs_ready);
        obs_gidx  = 0;
        for (int i = 0; i < NUM_REQ; i++) if (obs_ready[i]) obs_gidx = i;

        exp_ready = '0;
        g = -1;
        if (!s_rst && (pend_id.size() + buf_id.size() < FIFO_DEPTH)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_rr + k) % NUM_REQ;
                if (g < 0 && s_valid[idx]) g = idx;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end

        if (model_ok) begin
            chk("req_ready", 64'(obs_ready), 64'(exp_ready));
            chk("sq_valid_in", 64'(obs_sqv), 64'(m_sqv));
            chk("sq_x", 64'(obs_sqx), 64'(m_sqx));
            chk("resp_valid", 64'(obs_rv), 64'(buf_id.size() != 0));
            if (buf_id.size() != 0) begin
                chk("resp_id", 64'(obs_rid), 64'(buf_id[0]));
                chk("resp_data", 64'(obs_rdata), 64'(buf_d[0]));
            end
            chk("busy", 64'(obs_busy),
                64'((pend_id.size() != 0) || (buf_id.size() != 0) || m_sqv));
            chk("err_orphan", 64'(obs_err), 64'(m_err));
        end

        if (s_rst) begin
            pend_id.delete();
            pend_x.delete();
            buf_id.delete();
            buf_d.delete();
            m_rr     = 0;
            m_sqv    = 1'b0;
            m_sqx    = '0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (buf_id.size() != 0 && s_rready) begin
                tmp_id = buf_id.pop_front();
                tmp_x  = buf_d.pop_front();
            end
            if (uvo | s_force) begin
                if (pend_id.size() != 0) begin
                    tmp_id = pend_id.pop_front();
                    tmp_x  = pend_x.pop_front();
                    buf_id.push_back(tmp_id);
                    buf_d.push_back(unit_f(tmp_x));
                end else begin
                    m_err = 1'b1;
                end
            end
            if (g >= 0) begin
                pend_id.push_back(g);
                pend_x.push_back(s_data[g*WIDTH +: WIDTH]);
                m_rr  = (g + 1) % NUM_REQ;
                m_sqv = 1'b1;
                m_sqx = s_data[g*WIDTH +: WIDTH];
            end else begin
                m_sqv = 1'b0;
            end
        end

        // The unit shares rst, so a reset flushes its pipeline too.
        if (s_rst) begin
            for (int k = 0; k < UNIT_LAT; k++) begin
                uv[k] = 1'b0;
                ud[k] = '0;
            end
        end else begin
            for (int k = UNIT_LAT - 1; k > 0; k--) begin
                uv[k] = uv[k-1];
                ud[k] = ud[k-1];
            end
            uv[0] = obs_sqv;
            ud[0] = obs_sqx;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_valid  = '0;
        s_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_rready = 1'b1;
        s_force  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        s_rst = 1'b1;
        repeat (n) cycle();
        s_rst = 1'b0;
    endtask

    int n_hs;
    int exp_g;
    int exp_r;
    logic seen;

    initial begin
        checks   = 0;
        failures = 0;
        model_ok = 1'b0;
        m_rr     = 0;
        m_sqv    = 1'b0;
        m_sqx    = '0;
        m_err    = 1'b0;
        for (int k = 0; k < UNIT_LAT; k++) begin
            uv[k] = 1'b0;
            ud[k] = '0;
        end

        // Reset state.
        do_reset(2);
        idle_inputs();
        cycle();
        chk("rst_req_ready", 64'(obs_ready), 64'd0);
        chk("rst_sq_valid_in", 64'(obs_sqv), 64'd0);
        chk("rst_sq_x", 64'(obs_sqx), 64'd0);
        chk("rst_resp_valid", 64'(obs_rv), 64'd0);
        chk("rst_resp_id", 64'(obs_rid), 64'd0);
        chk("rst_resp_data", 64'(obs_rdata), 64'd0);
        chk("rst_busy", 64'(obs_busy), 64'd0);
        chk("rst_err", 64'(obs_err), 64'd0);

        // Single request from requester 2, identity result.
        do_reset(1);
        idle_inputs();
        s_valid = 4'b0100;
        s_data[2*WIDTH +: WIDTH] = 32'h0100_0000;
        cycle();
        chk("single_grant", 64'(obs_ready), 64'h4);
        s_valid = '0;
        cycle();
        chk("single_sqv", 64'(obs_sqv), 64'd1);
        chk("single_sqx", 64'(obs_sqx), 64'h0100_0000);
        cycle();
        chk("single_rv_c2", 64'(obs_rv), 64'd0);
        cycle();
        chk("single_rv_c3", 64'(obs_rv), 64'd0);
        cycle();
        chk("single_rv_c4", 64'(obs_rv), 64'd1);
        chk("single_rid", 64'(obs_rid), 64'd2);
        chk("single_rdata", 64'(obs_rdata), 64'h0100_0000);

        // All requesting with a ready consumer: strict rotation in and out.
        do_reset(1);
        idle_inputs();
        s_valid = 4'hF;
        exp_g = 0;
        exp_r = 0;
        repeat (24) begin
            s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
            if (obs_hs) begin
                chk("rot_grant", 64'(obs_gidx), 64'(exp_g));
                exp_g = (exp_g + 1) % NUM_REQ;
            end
            if (obs_rv) begin
                chk("rot_resp_id", 64'(obs_rid), 64'(exp_r));
                exp_r = (exp_r + 1) % NUM_REQ;
            end
        end

        // Stalled consumer: credit caps issues at the buffer depth.
        do_reset(1);
        idle_inputs();
        s_valid  = 4'hF;
        s_rready = 1'b0;
        n_hs = 0;
        repeat (10) begin
            cycle();
            n_hs += int'(obs_hs);
        end
        chk("stall_issues", 64'(n_hs), 64'd4);
        chk("stall_ready_zero", 64'(obs_ready), 64'd0);
        s_rready = 1'b1;
        cycle();
        chk("stall_pop_cycle_ready", 64'(obs_ready), 64'd0);
        s_rready = 1'b0;
        cycle();
        chk("stall_one_issue", 64'(obs_hs), 64'd1);
        n_hs = 0;
        repeat (5) begin
            cycle();
            n_hs += int'(obs_hs);
        end
        chk("stall_no_more", 64'(n_hs), 64'd0);

        // Pointer advance past the granted requester.
        do_reset(1);
        idle_inputs();
        s_valid = 4'b0010;
        cycle();
        chk("rr_grant1", 64'(obs_ready), 64'h2);
        s_valid = 4'b1000;
        cycle();
        chk("rr_grant3", 64'(obs_ready), 64'h8);
        s_valid = 4'b1001;
        cycle();
        chk("rr_wrap0", 64'(obs_ready), 64'h1);
        s_valid = '0;
        repeat (8) cycle();

        // Orphan result with nothing outstanding.
        do_reset(1);
        idle_inputs();
        repeat (2) cycle();
        s_force = 1'b1;
        cycle();
        s_force = 1'b0;
        cycle();
        chk("orphan_err", 64'(obs_err), 64'd1);
        chk("orphan_no_rv", 64'(obs_rv), 64'd0);
        repeat (4) cycle();
        chk("orphan_sticky", 64'(obs_err), 64'd1);
        chk("orphan_still_no_rv", 64'(obs_rv), 64'd0);
        do_reset(1);
        idle_inputs();
        cycle();
        chk("orphan_cleared", 64'(obs_err), 64'd0);

        // Reset with two in flight and two buffered.
        do_reset(1);
        idle_inputs();
        s_valid  = 4'hF;
        s_rready = 1'b0;
        repeat (4) cycle();
        s_valid = '0;
        cycle();
        cycle();
        chk("midrst_busy_before", 64'(obs_busy), 64'd1);
        chk("midrst_rv_before", 64'(obs_rv), 64'd1);
        s_rst = 1'b1;
        cycle();
        s_rst    = 1'b0;
        s_rready = 1'b1;
        cycle();
        chk("midrst_busy", 64'(obs_busy), 64'd0);
        chk("midrst_rv", 64'(obs_rv), 64'd0);
        chk("midrst_sqv", 64'(obs_sqv), 64'd0);
        chk("midrst_sqx", 64'(obs_sqx), 64'd0);
        chk("midrst_rid", 64'(obs_rid), 64'd0);
        chk("midrst_rdata", 64'(obs_rdata), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            cycle();
            seen |= obs_rv;
        end
        chk("midrst_no_late_resp", 64'(seen), 64'd0);

        // Randomized traffic against the model.
        do_reset(1);
        repeat (500) begin
            s_valid  = NUM_REQ'($urandom());
            s_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_rready = ($urandom_range(0, 9) < 7);
            s_force  = 1'b0;
            s_rst    = ($urandom_range(0, 99) == 0);
            cycle();
        end
        s_rst = 1'b0;
        idle_inputs();
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
